// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers bursty producer samples and strobes them into the FIR filter.
// Latency: a sample pushed into an empty FIFO at posedge k raises input_data_flag after posedge k+1.
// Backpressure: in_ready drops when the FIFO is full; strobes are spaced exactly GAP cycles apart.
// Optional build macro FEEDER_COUNT_EN adds a 16-bit sent_count output.
module fir_sample_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int GAP    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          data,
  output logic                       input_data_flag,
  output logic [$clog2(DEPTH):0]     fill_level
`ifdef FEEDER_COUNT_EN
  ,
  output logic [15:0]                sent_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Counter only needs to hold GAP-2; keep at least one bit so GAP<=2 still elaborates.
  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = (GAP > 1) ? GW'(GAP - 2) : '0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Sample storage and FIFO bookkeeping.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Output side and pacing state.
  logic [0:0]        state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              flag_q, flag_d;

  logic push;
  logic pop;

  // Full is derived from the registered count so in_ready never depends on in_valid.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop looks at the registered count, so a sample written this cycle cannot be popped this cycle.
  assign pop      = (state_q == ST_IDLE) && (count_q != '0);

  assign data            = data_q;
  assign input_data_flag = flag_q;
  assign fill_level      = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pacing FSM: IDLE pops and strobes, HOLD burns the remaining GAP-1 cycles.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    flag_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          data_d = mem_q[rd_ptr_q];
          flag_d = 1'b1;
          // With GAP == 1 the feeder can strobe every cycle, so no holdoff state is needed.
          if (GAP > 1) begin
            gap_d   = GAP_RELOAD;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Storage write; no reset needed because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // State registers; reset discards buffered samples and cancels any holdoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      data_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      flag_q   <= flag_d;
    end
  end

`ifdef FEEDER_COUNT_EN
  logic [15:0] sent_q;

  assign sent_count = sent_q;

  // Count strobes on the same edge that raises the flag; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_q <= '0;
    end else if (pop) begin
      sent_q <= sent_q + 16'd1;
    end
  end
`endif

endmodule
